// File: rtl/timer_entry_ctrl.sv
// Keypad entry and run control for the microwave timer: synchronizes raw inputs,
// shifts digits into a 3-digit BCD buffer, loads the counter chain and sequences cooking.
module timer_entry_ctrl #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       clrn,
  input  logic [9:0] keypad,
  input  logic       start_btn,
  input  logic       stop_btn,
  input  logic       door_closed,
  input  logic       tick,
  input  logic       timer_zero,
  output logic [3:0] min_data,
  output logic [3:0] tens_data,
  output logic [3:0] ones_data,
  output logic       loadn,
  output logic       cnt_en,
  output logic       mag_on,
  output logic       done,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ENTRY = 3'd1,
    ST_LOAD  = 3'd2,
    ST_RUN   = 3'd3,
    ST_PAUSE = 3'd4
  } state_e;

  localparam int NIN = 13;

  function automatic logic is_onehot(input logic [9:0] v);
    return (v != 10'd0) && ((v & (v - 10'd1)) == 10'd0);
  endfunction

  function automatic logic [3:0] digit_of(input logic [9:0] v);
    logic [3:0] d;
    d = 4'd0;
    for (int i = 0; i < 10; i++) begin
      if (v[i]) d = 4'(i);
    end
    return d;
  endfunction

  logic [SYNC_STAGES-1:0][NIN-1:0] sync_q;
  logic [NIN-1:0] hist_q;
  logic [NIN-1:0] raw_s;
  logic [NIN-1:0] sync_s;

  state_e     state_q, state_d;
  logic [3:0] buf_min_q, buf_min_d;
  logic [3:0] buf_tens_q, buf_tens_d;
  logic [3:0] buf_ones_q, buf_ones_d;
  logic       loadn_q, loadn_d;
  logic       done_q, done_d;

  logic key_evt_s, start_evt_s, stop_evt_s, door_s, buf_zero_s;

  // Bit packing: {door, stop, start, keypad[9:0]}
  assign raw_s  = {door_closed, stop_btn, start_btn, keypad};
  assign sync_s = sync_q[SYNC_STAGES-1];

  // Input synchronizer chain plus one history stage for edge detection
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      sync_q <= '0;
      hist_q <= '0;
    end else begin
      sync_q[0] <= raw_s;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
      hist_q <= sync_s;
    end
  end

  assign key_evt_s   = is_onehot(sync_s[9:0]) & ~is_onehot(hist_q[9:0]);
  assign start_evt_s = sync_s[10] & ~hist_q[10];
  assign stop_evt_s  = sync_s[11] & ~hist_q[11];
  assign door_s      = sync_s[12];
  assign buf_zero_s  = ({buf_min_q, buf_tens_q, buf_ones_q} == 12'd0);

  // Control state, entry buffer and registered strobes
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state_q    <= ST_IDLE;
      buf_min_q  <= 4'd0;
      buf_tens_q <= 4'd0;
      buf_ones_q <= 4'd0;
      loadn_q    <= 1'b1;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      buf_min_q  <= buf_min_d;
      buf_tens_q <= buf_tens_d;
      buf_ones_q <= buf_ones_d;
      loadn_q    <= loadn_d;
      done_q     <= done_d;
    end
  end

  // Next-state, buffer update and strobe decode; an ignored start lets a key through
  always_comb begin
    state_d    = state_q;
    buf_min_d  = buf_min_q;
    buf_tens_d = buf_tens_q;
    buf_ones_d = buf_ones_q;
    loadn_d    = 1'b1;
    done_d     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (key_evt_s) begin
          buf_min_d  = buf_tens_q;
          buf_tens_d = buf_ones_q;
          buf_ones_d = digit_of(sync_s[9:0]);
          state_d    = ST_ENTRY;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ENTRY: begin
        if (stop_evt_s) begin
          buf_min_d  = 4'd0;
          buf_tens_d = 4'd0;
          buf_ones_d = 4'd0;
          state_d    = ST_IDLE;
        end else if (start_evt_s && door_s && !buf_zero_s) begin
          state_d = ST_LOAD;
          loadn_d = 1'b0;
        end else if (key_evt_s) begin
          buf_min_d  = buf_tens_q;
          buf_tens_d = buf_ones_q;
          buf_ones_d = digit_of(sync_s[9:0]);
        end else begin
          state_d = ST_ENTRY;
        end
      end
      ST_LOAD: begin
        state_d = ST_RUN;
      end
      ST_RUN: begin
        if (timer_zero) begin
          done_d     = 1'b1;
          buf_min_d  = 4'd0;
          buf_tens_d = 4'd0;
          buf_ones_d = 4'd0;
          state_d    = ST_IDLE;
        end else if (stop_evt_s || !door_s) begin
          state_d = ST_PAUSE;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_PAUSE: begin
        if (stop_evt_s) begin
          buf_min_d  = 4'd0;
          buf_tens_d = 4'd0;
          buf_ones_d = 4'd0;
          state_d    = ST_IDLE;
        end else if (start_evt_s && door_s) begin
          state_d = ST_RUN;
        end else begin
          state_d = ST_PAUSE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Counter enable and magnetron follow the current state and the synchronized door
  always_comb begin
    cnt_en = 1'b0;
    mag_on = 1'b0;
    if (state_q == ST_LOAD) begin
      cnt_en = 1'b1;
    end else if (state_q == ST_RUN) begin
      cnt_en = tick & door_s;
      mag_on = door_s;
    end else begin
      cnt_en = 1'b0;
      mag_on = 1'b0;
    end
  end

  assign min_data  = buf_min_q;
  assign tens_data = (buf_tens_q > 4'd5) ? 4'd5 : buf_tens_q;
  assign ones_data = buf_ones_q;
  assign loadn     = loadn_q;
  assign done      = done_q;
  assign state     = state_q;

endmodule

// File: tb/tb_timer_entry_ctrl.sv
// Self-checking bench for timer_entry_ctrl: directed scenarios plus random stimulus,
// compared every cycle against a decimal-arithmetic reference model.
module tb_timer_entry_ctrl;

  localparam int S = 2;

  logic       clk = 1'b0;
  logic       clrn;
  logic [9:0] keypad;
  logic       start_btn, stop_btn, door_closed, tick, timer_zero;
  logic [3:0] min_data, tens_data, ones_data;
  logic       loadn, cnt_en, mag_on, done;
  logic [2:0] state;

  timer_entry_ctrl #(.SYNC_STAGES(S)) dut (
    .clk(clk), .clrn(clrn), .keypad(keypad), .start_btn(start_btn),
    .stop_btn(stop_btn), .door_closed(door_closed), .tick(tick),
    .timer_zero(timer_zero), .min_data(min_data), .tens_data(tens_data),
    .ones_data(ones_data), .loadn(loadn), .cnt_en(cnt_en), .mag_on(mag_on),
    .done(done), .state(state)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s obs=%0d exp=%0d at %0t", tag, obs, exp, $time);
  endtask

  // Reference model: buffer held as a decimal number 0..999, states as plain ints
  int         m_state;
  int         m_val;
  bit         m_loadn, m_done;
  logic [12:0] m_pipe [S];
  logic [12:0] m_hist;

  function automatic bit one_hot(input logic [9:0] v);
    return $countones(v) == 1;
  endfunction

  function automatic int digit_of(input logic [9:0] v);
    for (int i = 0; i < 10; i++) if (v[i]) return i;
    return 0;
  endfunction

  task automatic model_reset();
    m_state = 0; m_val = 0; m_loadn = 1'b1; m_done = 1'b0; m_hist = '0;
    for (int i = 0; i < S; i++) m_pipe[i] = '0;
  endtask

  task automatic model_edge();
    logic [12:0] sy;
    bit kev, sev, pev, dr;
    sy  = m_pipe[S-1];
    kev = one_hot(sy[9:0]) && !one_hot(m_hist[9:0]);
    sev = sy[10] && !m_hist[10];
    pev = sy[11] && !m_hist[11];
    dr  = sy[12];
    m_loadn = 1'b1;
    m_done  = 1'b0;
    case (m_state)
      0: if (kev) begin m_val = (m_val * 10 + digit_of(sy[9:0])) % 1000; m_state = 1; end
      1: begin
        if (pev) begin m_val = 0; m_state = 0; end
        else if (sev && dr && m_val != 0) begin m_state = 2; m_loadn = 1'b0; end
        else if (kev) m_val = (m_val * 10 + digit_of(sy[9:0])) % 1000;
      end
      2: m_state = 3;
      3: begin
        if (timer_zero) begin m_done = 1'b1; m_val = 0; m_state = 0; end
        else if (pev || !dr) m_state = 4;
      end
      4: begin
        if (pev) begin m_val = 0; m_state = 0; end
        else if (sev && dr) m_state = 3;
      end
      default: m_state = 0;
    endcase
    m_hist = sy;
    for (int i = S - 1; i > 0; i--) m_pipe[i] = m_pipe[i-1];
    m_pipe[0] = {door_closed, stop_btn, start_btn, keypad};
  endtask

  // One cycle, entered and left at a falling edge: check outputs, then clock the model
  task automatic step();
    int t;
    bit dr;
    #1;
    dr = m_pipe[S-1][12];
    t  = (m_val / 10) % 10;
    check_eq("state", state, m_state);
    check_eq("min_data", min_data, m_val / 100);
    check_eq("tens_data", tens_data, (t > 5) ? 5 : t);
    check_eq("ones_data", ones_data, m_val % 10);
    check_eq("loadn", loadn, m_loadn);
    check_eq("done", done, m_done);
    check_eq("cnt_en", cnt_en, (m_state == 2) || (m_state == 3 && tick && dr));
    check_eq("mag_on", mag_on, (m_state == 3) && dr);
    @(posedge clk);
    if (clrn) model_edge();
    @(negedge clk);
  endtask

  task automatic press(input int d);
    keypad = 10'd1 << d;
    repeat (3) step();
    keypad = 10'd0;
    repeat (3) step();
  endtask

  task automatic press_start();
    start_btn = 1'b1; repeat (3) step();
    start_btn = 1'b0; repeat (3) step();
  endtask

  int low_cnt;

  initial begin
    clrn = 1'b0; keypad = '0; start_btn = 0; stop_btn = 0;
    door_closed = 1'b1; tick = 0; timer_zero = 0;
    model_reset();
    @(negedge clk);
    repeat (2) step();
    clrn = 1'b1;
    repeat (4) step();

    // Keys 1,3,0
    press(1); press(3); press(0);
    check_eq("tp_130_min", min_data, 1);
    check_eq("tp_130_tens", tens_data, 3);
    check_eq("tp_130_ones", ones_data, 0);
    check_eq("tp_130_state", state, 1);

    // Keys 9,9,9,4 then start: tens clipped, single-cycle load
    press(9); press(9); press(9); press(4);
    check_eq("tp_clip_tens", tens_data, 5);
    low_cnt = 0;
    start_btn = 1'b1;
    for (int i = 0; i < 6; i++) begin
      if (i == 3) start_btn = 1'b0;
      if (loadn === 1'b0) begin
        low_cnt++;
        check_eq("tp_load_data", {min_data, tens_data, ones_data}, 12'h954);
      end
      step();
    end
    check_eq("tp_load_width", low_cnt, 1);

    // Run with tick every 10 cycles, then timer_zero ends cooking
    for (int i = 0; i < 30; i++) begin tick = (i % 10 == 0); step(); end
    tick = 0; timer_zero = 1'b1; step(); timer_zero = 1'b0;
    check_eq("tp_done", done, 1);
    step();
    check_eq("tp_done_width", done, 0);
    check_eq("tp_idle", state, 0);

    // Key 1, start, open door in RUN -> PAUSE; close and start -> RUN without reload
    press(1); press_start();
    check_eq("tp_run", state, 3);
    door_closed = 1'b0; repeat (4) step();
    check_eq("tp_pause", state, 4);
    check_eq("tp_pause_mag", mag_on, 0);
    door_closed = 1'b1; repeat (3) step();
    low_cnt = 0;
    start_btn = 1'b1;
    for (int i = 0; i < 6; i++) begin
      if (i == 3) start_btn = 1'b0;
      if (loadn === 1'b0) low_cnt++;
      step();
    end
    check_eq("tp_resume_noload", low_cnt, 0);
    check_eq("tp_resume", state, 3);

    // Asynchronous reset in RUN
    clrn = 1'b0; tick = 1'b1; model_reset();
    #1;
    check_eq("tp_areset_mag", mag_on, 0);
    check_eq("tp_areset_cnt", cnt_en, 0);
    step(); clrn = 1'b1; tick = 1'b0; step();

    // Zero buffer: start ignored; start+stop together clears
    press(0);
    press_start();
    check_eq("tp_zero_start", state, 1);
    press(7);
    start_btn = 1'b1; stop_btn = 1'b1; repeat (3) step();
    start_btn = 1'b0; stop_btn = 1'b0; repeat (3) step();
    check_eq("tp_stop_idle", state, 0);
    check_eq("tp_stop_clear", ones_data, 0);

    // Multi-key pattern is not an event; key 5 afterwards shifts once
    keypad = 10'b0000010010; repeat (3) step();
    keypad = 10'd0; repeat (3) step();
    check_eq("tp_multi_state", state, 0);
    press(5);
    check_eq("tp_key5", {min_data, tens_data, ones_data}, 12'h005);

    // Randomized phase
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(7) == 0) begin
        case ($urandom_range(3))
          0, 1: keypad = 10'd1 << $urandom_range(9);
          2:    keypad = 10'd0;
          default: keypad = 10'($urandom);
        endcase
      end
      if ($urandom_range(9) == 0) start_btn = ~start_btn;
      if ($urandom_range(29) == 0) stop_btn = ~stop_btn;
      if ($urandom_range(39) == 0) door_closed = ~door_closed;
      tick = (c % 10 == 0);
      timer_zero = ($urandom_range(59) == 0);
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/timer_entry_ctrl.md
# timer_entry_ctrl

Keypad entry and run-control stage for the microwave timer, sitting directly upstream of the BCD down-counter chain (minutes, tens-of-seconds mod-6, seconds). It turns raw button and keypad inputs into a 3-digit BCD entry buffer. It loads that buffer into the counter chain with a one-cycle active-low load strobe and gates the counter enable from the 1 Hz tick. It also sequences IDLE/ENTRY/RUN/PAUSE and drives the magnetron enable.

## Interface
- SYNC_STAGES, 2, flip-flop depth of the input synchronizers for keypad, start_btn, stop_btn and door_closed (minimum 2)
- clk  in  1  system clock
- clrn  in  1  reset, asynchronous, active-low
- keypad  in  10  raw digit keys 0..9, active-high, bit i = digit i
- start_btn  in  1  raw start button, active-high
- stop_btn  in  1  raw stop/clear button, active-high
- door_closed  in  1  raw door switch, 1 = closed
- tick  in  1  synchronous 1 Hz strobe, one clk wide
- timer_zero  in  1  synchronous, 1 when every counter digit is 0
- min_data  out  4  BCD minutes load value
- tens_data  out  4  BCD tens-of-seconds load value, range 0..5
- ones_data  out  4  BCD seconds load value
- loadn  out  1  active-low load strobe to the counter chain
- cnt_en  out  1  counter chain enable
- mag_on  out  1  magnetron enable
- done  out  1  one-cycle pulse when cooking completes
- state  out  3  current state code, for debug

## Operation
- Inputs are synchronized through SYNC_STAGES flip-flops, plus one history flop per synchronized signal. Events are rising edges of the synchronized signal.
- Key event: the synchronized keypad goes from "not exactly one bit set" to "exactly one bit set". Multi-key patterns are never events. Digit = index of the set bit.
- Buffer buf_min, buf_tens, buf_ones, each 4 bits. On a key event: buf_min<=buf_tens, buf_tens<=buf_ones, buf_ones<=digit. The oldest digit is discarded.
- Load values: min_data=buf_min, ones_data=buf_ones, tens_data=min(buf_tens,5).
- States: IDLE=0, ENTRY=1, LOAD=2, RUN=3, PAUSE=4.
- IDLE:
  - key event -> shift, go ENTRY.
  - start and stop are ignored.
- ENTRY:
  - key event -> shift.
  - stop -> clear buffer, go IDLE.
  - start with door closed and buffer not all zero -> LOAD.
  - start with door open or buffer all zero -> ignored.
- LOAD: exactly one cycle, with loadn=0 and cnt_en=1, then go RUN.
- RUN:
  - cnt_en = tick & door_closed_sync. mag_on = door_closed_sync.
  - timer_zero=1 -> done=1 for one cycle, clear buffer, go IDLE.
  - stop, or door_closed_sync=0 -> PAUSE.
- PAUSE:
  - cnt_en=0, mag_on=0.
  - start with door closed -> RUN. No reload; the counters keep their value.
  - stop -> clear buffer, go IDLE.
- Key events in LOAD, RUN and PAUSE are ignored.
- Priority within one cycle: stop > start > key event. In RUN: timer_zero > stop/door.

## Timing
- Reset values: state=IDLE, buffer=0, all data outputs 0, loadn=1, cnt_en=0, mag_on=0, done=0. Synchronizer and history flops are all 0.
- Input latency: a raw input that is stable before edge k becomes an event acted on at edge k+SYNC_STAGES (edge k+2 at default).
- Start-to-load: the start event edge enters LOAD, and loadn is low for the following cycle only. The counter chain samples the data at the edge that leaves LOAD.
- data outputs change only on key events or on a clear. They are stable throughout LOAD.
- done and loadn are registered, glitch-free, and exactly one cycle wide.
- cnt_en is combinational from state, tick and the synchronized door. It is never high in IDLE, ENTRY or PAUSE.
- clrn asserted mid-RUN drops mag_on and cnt_en asynchronously and returns all outputs to their reset values.

## Test plan
- Reset, then press keys 1,3,0 → after 3 events: min_data=1, tens_data=3, ones_data=0, state=ENTRY.
- Press keys 9,9,9,4 → buf_min=9, buf_tens=9, buf_ones=4 → tens_data=5. Start with door closed → single-cycle loadn=0 with data 9,5,4.
- Press key 1, start, then open the door in RUN → state=PAUSE and mag_on=0 within 2 cycles of sync. Close the door and press start → RUN with no loadn pulse.
- From ENTRY with buffer 0,0,0, press start → stays ENTRY, loadn stays 1. Start and stop asserted in the same cycle → buffer cleared, IDLE.
- In RUN, drive tick every 10 cycles and raise timer_zero → done high for exactly one cycle, state=IDLE, cnt_en=0, mag_on=0.
- keypad=10'b0000010010, then release and press key 5 alone → no shift for the multi-key pattern; a single shift of 5 afterwards.
